sram_req_port: RTL and testbench

- Request-side front end for one port of the dual-port SRAM wrapper (WIDTH=256 by DEPTH 64/128/256).
- Converts a valid/ready read/write request stream into the wrapper's active-low port signals (enable_x_n, write_enable_x_n, address_x, data_x).
- Captures the 1-cycle read data q_x into a 2-entry response buffer, exposed as a valid/ready response stream.
- Two instances, one per port, sit between the accelerator datapath and the SRAM wrapper.

---
 rtl/sram_req_port_if.sv | 32 +++
 rtl/sram_req_port.sv | 104 ++++++++++
 tb/tb_sram_req_port.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_port_if.sv
// ============================================================================
// Module      : sram_req_port_if
// Description : Request/response valid-ready bundle for one SRAM port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_req_port_if #(
  parameter int WIDTH  = 256,
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

`default_nettype wire

// File: rtl/sram_req_port.sv
// ============================================================================
// Module      : sram_req_port
// Description : Valid/ready front end for one port of the dual-port SRAM
//               wrapper, with a 2-entry read response buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_req_port #(
  parameter int WIDTH  = 256,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  sram_req_port_if.slave         bus,
  output logic                   sram_enable_n,
  output logic                   sram_write_enable_n,
  output logic [ADDR_W-1:0]      sram_address,
  output logic [WIDTH-1:0]       sram_data,
  input  wire logic [WIDTH-1:0]  sram_q,
  output logic                   busy
);

  generate
    if (WIDTH != 256) begin : g_bad_width
      $error("sram_req_port: WIDTH must be 256");
    end
    if (DEPTH != 64 && DEPTH != 128 && DEPTH != 256) begin : g_bad_depth
      $error("sram_req_port: DEPTH must be 64, 128 or 256");
    end
    if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
      $error("sram_req_port: ADDR_W must not be overridden");
    end
  endgenerate

  logic             rd_pend;
  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [WIDTH-1:0] buf_mem [2];

  logic             acc;
  logic             pop;
  logic             push;
  logic [2:0]       occupancy;

  assign pop  = bus.rsp_valid & bus.rsp_ready;
  assign push = rd_pend;

  // Reads in flight plus buffered entries, net of this cycle's pop, must leave room.
  assign occupancy     = {1'b0, count} + {2'b00, rd_pend} - {2'b00, pop};
  assign bus.req_ready = rst_n & (bus.req_write | (occupancy < 3'd2));
  assign acc           = bus.req_valid & bus.req_ready;

  assign sram_enable_n       = ~acc;
  assign sram_write_enable_n = ~(acc & bus.req_write);
  assign sram_address        = bus.req_addr;
  assign sram_data           = bus.req_wdata;

  assign bus.rsp_valid = (count != 2'd0);
  assign bus.rsp_rdata = buf_mem[rd_ptr];
  assign busy          = rd_pend | (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= acc & ~bus.req_write;
    end
  end

  // sram_q is valid in the cycle after the read was accepted, i.e. while rd_pend is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= sram_q;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  overflow_chk : assert property (@(posedge clk) disable iff (!rst_n) !(push && count == 2'd2))
    else $fatal(1, "sram_req_port: response buffer overflow");
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_req_port.sv
// ============================================================================
// Module      : tb_sram_req_port
// Description : Directed and random stimulus against a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_req_port;

  localparam int WIDTH  = 256;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  logic              sram_enable_n;
  logic              sram_write_enable_n;
  logic [ADDR_W-1:0] sram_address;
  logic [WIDTH-1:0]  sram_data;
  logic [WIDTH-1:0]  sram_q;
  logic              busy;

  sram_req_port_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  sram_req_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .bus                 (bus),
    .sram_enable_n       (sram_enable_n),
    .sram_write_enable_n (sram_write_enable_n),
    .sram_address        (sram_address),
    .sram_data           (sram_data),
    .sram_q              (sram_q),
    .busy                (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro: samples pins at the clock edge, read data appears the next cycle.
  logic [WIDTH-1:0] sram_mem [DEPTH];
  initial begin
    sram_q = '0;
    for (int i = 0; i < DEPTH; i++) sram_mem[i] = '0;
  end
  always @(posedge clk) begin
    if (!sram_enable_n) begin
      if (!sram_write_enable_n) sram_mem[sram_address] <= sram_data;
      else                      sram_q <= sram_mem[sram_address];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Reference: word array of committed writes plus a queue of accepted, unconsumed reads.
  logic [WIDTH-1:0] model_mem [DEPTH];
  ent_t             pend_q [$];
  ent_t             pop_log [$];
  initial for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

  always @(negedge clk) begin
    bit exp_valid, exp_ready, exp_pop, exp_acc;
    int n;
    if (!rst_n) begin
      chk("rst req_ready", WIDTH'(bus.req_ready), '0);
      chk("rst rsp_valid", WIDTH'(bus.rsp_valid), '0);
      chk("rst busy", WIDTH'(busy), '0);
      chk("rst enable_n", WIDTH'(sram_enable_n), WIDTH'(1));
      chk("rst write_enable_n", WIDTH'(sram_write_enable_n), WIDTH'(1));
      chk("rst rsp_rdata", bus.rsp_rdata, '0);
      pend_q.delete();
    end else begin
      n         = pend_q.size();
      exp_valid = (n > 0) && (pend_q[0].cyc + 2 <= cyc);
      exp_pop   = exp_valid && bus.rsp_ready;
      exp_ready = bus.req_write || ((n - int'(exp_pop)) < 2);
      exp_acc   = bus.req_valid && exp_ready;
      chk("req_ready", WIDTH'(bus.req_ready), WIDTH'(exp_ready));
      chk("rsp_valid", WIDTH'(bus.rsp_valid), WIDTH'(exp_valid));
      chk("busy", WIDTH'(busy), WIDTH'(n != 0));
      chk("enable_n", WIDTH'(sram_enable_n), WIDTH'(!exp_acc));
      chk("write_enable_n", WIDTH'(sram_write_enable_n), WIDTH'(!(exp_acc && bus.req_write)));
      chk("address", WIDTH'(sram_address), WIDTH'(bus.req_addr));
      chk("data", sram_data, bus.req_wdata);
      if (exp_valid) chk("rsp_rdata", bus.rsp_rdata, pend_q[0].data);
      if (exp_pop) begin
        pop_log.push_back('{data: bus.rsp_rdata, cyc: cyc});
        void'(pend_q.pop_front());
      end
      if (exp_acc && bus.req_write) model_mem[bus.req_addr] = bus.req_wdata;
      else if (exp_acc) pend_q.push_back('{data: model_mem[bus.req_addr], cyc: cyc});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit w, input int a, input logic [WIDTH-1:0] d, input bit rr);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = ADDR_W'(a);
    bus.req_wdata = d;
    bus.rsp_ready = rr;
  endtask

  function automatic logic [WIDTH-1:0] pat(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(k);
    return {8{w}};
  endfunction

  initial begin
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] rd;
    int t0;
    int nlog;
    wa = {8{32'hA5A5_0001}};
    drive(0, 0, 0, '0, 0);
    repeat (3) next_cycle();
    rst_n = 1'b1;

    // Idle after reset.
    drive(0, 0, 0, '0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle busy", WIDTH'(busy), '0);
      chk("idle req_ready", WIDTH'(bus.req_ready), WIDTH'(1));
      next_cycle();
    end
    chk("idle enable_n", WIDTH'(sram_enable_n), WIDTH'(1));

    // Write then read the same address on consecutive cycles.
    drive(1, 1, 5, wa, 0);
    @(negedge clk);
    chk("wr write_enable_n", WIDTH'(sram_write_enable_n), '0);
    next_cycle();
    drive(1, 0, 5, '0, 0);
    next_cycle();
    drive(0, 0, 0, '0, 1);
    @(negedge clk);
    chk("rd T+1 rsp_valid", WIDTH'(bus.rsp_valid), '0);
    chk("wr one-cycle write_enable_n", WIDTH'(sram_write_enable_n), WIDTH'(1));
    next_cycle();
    @(negedge clk);
    chk("rd T+2 rsp_valid", WIDTH'(bus.rsp_valid), WIDTH'(1));
    chk("rd T+2 rsp_rdata", bus.rsp_rdata, wa);
    next_cycle();

    // Back-to-back reads of addresses 0..7.
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, k, pat(k), 1);
      next_cycle();
    end
    pop_log.delete();
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, k, '0, 1);
      @(negedge clk);
      chk("b2b req_ready", WIDTH'(bus.req_ready), WIDTH'(1));
      next_cycle();
    end
    drive(0, 0, 0, '0, 1);
    repeat (4) next_cycle();
    chk("b2b count", WIDTH'(pop_log.size()), WIDTH'(8));
    for (int k = 0; k < 8 && k < pop_log.size(); k++) begin
      chk("b2b cycle", WIDTH'(pop_log[k].cyc), WIDTH'(t0 + 2 + k));
      chk("b2b data", pop_log[k].data, pat(k));
    end

    // Back-pressure: third read refused until a pop frees space.
    drive(1, 0, 1, '0, 0);
    next_cycle();
    drive(1, 0, 2, '0, 0);
    next_cycle();
    drive(1, 0, 3, '0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp req_ready", WIDTH'(bus.req_ready), '0);
      chk("bp enable_n", WIDTH'(sram_enable_n), WIDTH'(1));
      if (i > 0) chk("bp hold rdata", bus.rsp_rdata, pat(1));
      next_cycle();
    end
    drive(1, 0, 3, '0, 1);
    @(negedge clk);
    chk("bp pop req_ready", WIDTH'(bus.req_ready), WIDTH'(1));
    next_cycle();

    // Writes while the buffer is full are taken immediately.
    for (int k = 1; k <= 3; k++) begin
      drive(1, 1, k, pat(100 + k), 0);
      @(negedge clk);
      chk("full wr req_ready", WIDTH'(bus.req_ready), WIDTH'(1));
      chk("full wr rdata", bus.rsp_rdata, pat(2));
      next_cycle();
    end

    // Reset pulse with a response buffered and a read in flight.
    drive(1, 0, 4, '0, 1);
    next_cycle();
    drive(0, 0, 0, '0, 0);
    nlog = pop_log.size();
    rst_n = 1'b0;
    #1;
    chk("mid rst rsp_valid", WIDTH'(bus.rsp_valid), '0);
    chk("mid rst busy", WIDTH'(busy), '0);
    next_cycle();
    rst_n = 1'b1;
    drive(0, 0, 0, '0, 1);
    repeat (6) next_cycle();
    chk("post rst no response", WIDTH'(pop_log.size()), WIDTH'(nlog));
    chk("post rst busy", WIDTH'(busy), '0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      for (int j = 0; j < 8; j++) rd[j*32 +: 32] = $urandom;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            int'($urandom_range(0, DEPTH - 1)), rd, $urandom_range(0, 9) < 6);
      next_cycle();
    end
    drive(0, 0, 0, '0, 1);
    repeat (8) next_cycle();
    chk("drain busy", WIDTH'(busy), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
